// File: rtl/ccl_pkg.sv
// Shared definitions for the connected-component labelling path (label scan and union_find).
package ccl_pkg;

  localparam int unsigned CCL_ADDR_WIDTH = 8;

  localparam logic [1:0] UF_OP_FIND  = 2'b10;
  localparam logic [1:0] UF_OP_UNION = 2'b01;

  localparam int unsigned LABEL_BG = 0;

  typedef logic [CCL_ADDR_WIDTH-1:0] label_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_UF_WAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/ccl_line_buffer.sv
// One line of provisional labels: simple dual-port RAM with registered, enabled read (BRAM style).
module ccl_line_buffer #(
  parameter int unsigned DEPTH = 1280,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 11
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset on the array or read register so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ccl_label_scan.sv
// First CCL pass: raster-order provisional labelling (4-connectivity) with union requests to union_find.
module ccl_label_scan
  import ccl_pkg::*;
#(
  parameter int unsigned IMG_W      = 1280,
  parameter int unsigned IMG_H      = 720,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned COL_W      = 11,
  parameter int unsigned ROW_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  input  logic                  pix_bin,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic                  label_valid,
  output logic [ADDR_WIDTH-1:0] label_out,
  output logic [1:0]            uf_op,
  output logic [ADDR_WIDTH-1:0] uf_node1,
  output logic [ADDR_WIDTH-1:0] uf_node2,
  output logic                  uf_start,
  input  logic                  uf_done,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] labels_used,
  output logic                  label_overflow
);

  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] LBL_MAX   = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] LBL_BG    = ADDR_WIDTH'(LABEL_BG);
  localparam logic [ADDR_WIDTH-1:0] LBL_FIRST = ADDR_WIDTH'(1);

  scan_state_e state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [ADDR_WIDTH-1:0] left_q, left_d;
  logic [ADDR_WIDTH-1:0] label_q, label_d;
  logic [ADDR_WIDTH-1:0] n1_q, n1_d, n2_q, n2_d;
  logic [ADDR_WIDTH-1:0] used_q, used_d;
  logic [1:0]            op_q, op_d;
  logic ovf_q, ovf_d, pend_q, pend_d, ready_q, ready_d;
  logic lv_q, lv_d, start_q, start_d, fdone_q, fdone_d;

  logic                  accept_c, sof_c, proc_c, fresh_c, merge_c;
  logic                  last_col_c, last_pix_c, base_ovf_c;
  logic [COL_W-1:0]      cur_col_c, nxt_col_c;
  logic [ROW_W-1:0]      cur_row_c;
  logic [ADDR_WIDTH-1:0] base_c, lft_c, up_c, lo_c, hi_c, lbl_c, lb_rdata;

  // Up-neighbour store; column c+1 is fetched while pixel c is labelled.
  ccl_line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(ADDR_WIDTH),
    .AW   (COL_W)
  ) u_line_buffer (
    .clk    (clk),
    .we_i   (proc_c),
    .waddr_i(cur_col_c),
    .wdata_i(lbl_c),
    .re_i   (proc_c),
    .raddr_i(nxt_col_c),
    .rdata_o(lb_rdata)
  );

  // Neighbourhood and label decision for the pixel presented this cycle.
  always_comb begin
    accept_c   = pix_valid & ready_q;
    sof_c      = accept_c & pix_sof;
    proc_c     = accept_c & ((state_q == ST_RUN) | ((state_q == ST_IDLE) & pix_sof));
    cur_col_c  = sof_c ? '0 : col_q;
    cur_row_c  = sof_c ? '0 : row_q;
    base_c     = sof_c ? LBL_FIRST : next_q;
    base_ovf_c = sof_c ? 1'b0 : ovf_q;
    lft_c      = (cur_col_c == '0) ? LBL_BG : left_q;
    up_c       = (cur_row_c == '0) ? LBL_BG : lb_rdata;
    lo_c       = (lft_c < up_c) ? lft_c : up_c;
    hi_c       = (lft_c < up_c) ? up_c : lft_c;
    fresh_c    = pix_bin & (lft_c == LBL_BG) & (up_c == LBL_BG);
    merge_c    = pix_bin & (lft_c != LBL_BG) & (up_c != LBL_BG) & (lft_c != up_c);
    lbl_c      = LBL_BG;
    if (!pix_bin)     lbl_c = LBL_BG;
    else if (fresh_c) lbl_c = base_c;
    else if (merge_c) lbl_c = lo_c;
    else              lbl_c = (lft_c != LBL_BG) ? lft_c : up_c;
    last_col_c = (cur_col_c == LAST_COL);
    last_pix_c = last_col_c & (cur_row_c == LAST_ROW);
    nxt_col_c  = last_col_c ? '0 : cur_col_c + COL_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    next_d  = next_q;
    ovf_d   = ovf_q;
    left_d  = left_q;
    pend_d  = pend_q;
    lv_d    = 1'b0;
    label_d = label_q;
    start_d = 1'b0;
    op_d    = op_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    fdone_d = 1'b0;
    used_d  = used_q;

    case (state_q)
      ST_UF_WAIT: begin
        if (uf_done) begin
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!pend_q || uf_done) begin
          pend_d  = 1'b0;
          fdone_d = 1'b1;
          used_d  = ovf_q ? LBL_MAX : next_q - LBL_FIRST;
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    if (proc_c) begin
      col_d  = nxt_col_c;
      row_d  = last_col_c ? (last_pix_c ? '0 : cur_row_c + ROW_W'(1)) : cur_row_c;
      next_d = base_c;
      ovf_d  = base_ovf_c;
      // Saturate at the top label instead of wrapping into background.
      if (fresh_c) begin
        if (base_c == LBL_MAX) ovf_d = 1'b1;
        else                   next_d = base_c + LBL_FIRST;
      end
      left_d  = lbl_c;
      lv_d    = 1'b1;
      label_d = lbl_c;
      if (merge_c) begin
        start_d = 1'b1;
        op_d    = UF_OP_UNION;
        n1_d    = lo_c;
        n2_d    = hi_c;
        pend_d  = 1'b1;
      end
      state_d = last_pix_c ? ST_FLUSH : (merge_c ? ST_UF_WAIT : ST_RUN);
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      next_q  <= LBL_FIRST;
      ovf_q   <= 1'b0;
      left_q  <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
      lv_q    <= 1'b0;
      label_q <= '0;
      start_q <= 1'b0;
      op_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      fdone_q <= 1'b0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      next_q  <= next_d;
      ovf_q   <= ovf_d;
      left_q  <= left_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      lv_q    <= lv_d;
      label_q <= label_d;
      start_q <= start_d;
      op_q    <= op_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      fdone_q <= fdone_d;
      used_q  <= used_d;
    end
  end

  assign pix_ready      = ready_q;
  assign label_valid    = lv_q;
  assign label_out      = label_q;
  assign uf_op          = op_q;
  assign uf_node1       = n1_q;
  assign uf_node2       = n2_q;
  assign uf_start       = start_q;
  assign frame_done     = fdone_q;
  assign labels_used    = used_q;
  assign label_overflow = ovf_q;

endmodule

// File: tb/tb_ccl_label_scan.sv
// Self-checking bench for ccl_label_scan on an 8x4 image with 3-bit labels and a 3-cycle union_find stand-in.
module tb_ccl_label_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pix_valid, pix_bin, pix_sof, pix_ready;
  logic       label_valid, uf_start, uf_done, frame_done, label_overflow;
  logic [2:0] label_out, uf_node1, uf_node2, labels_used;
  logic [1:0] uf_op;

  always #5 clk = ~clk;

  ccl_label_scan #(
    .IMG_W(8), .IMG_H(4), .ADDR_WIDTH(3), .COL_W(3), .ROW_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pix_valid(pix_valid), .pix_bin(pix_bin), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .label_valid(label_valid), .label_out(label_out),
    .uf_op(uf_op), .uf_node1(uf_node1), .uf_node2(uf_node2), .uf_start(uf_start),
    .uf_done(uf_done), .frame_done(frame_done), .labels_used(labels_used),
    .label_overflow(label_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // union_find stand-in: done pulses three cycles after the request
  int uf_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf_cnt  <= 0;
      uf_done <= 1'b0;
    end else begin
      uf_done <= 1'b0;
      if (uf_start) begin
        if (uf_cnt != 0) check_eq("uf_overlap", 1, 0);
        uf_cnt <= 3;
      end else if (uf_cnt > 0) begin
        uf_cnt <= uf_cnt - 1;
        if (uf_cnt == 1) uf_done <= 1'b1;
      end
    end
  end

  // Reference labeller and scoreboard queues
  int m_line[8];
  int m_left, m_col, m_row, m_next;
  bit m_ovf, m_run;
  int q_lab[$], q_ovf[$], q_uf[$], q_n1[$], q_n2[$], q_used[$], q_fovf[$];

  task automatic model_push(input logic b, input logic s);
    int l, u, lab;
    if (s) begin
      m_col = 0; m_row = 0; m_next = 1; m_ovf = 0; m_run = 1;
    end
    if (!m_run) return;
    l = (m_col == 0) ? 0 : m_left;
    u = (m_row == 0) ? 0 : m_line[m_col];
    if (!b) lab = 0;
    else if (l == 0 && u == 0) begin
      lab = m_next;
      if (m_next == 7) m_ovf = 1; else m_next++;
    end
    else if (l == 0) lab = u;
    else if (u == 0 || l == u) lab = l;
    else begin
      lab = (l < u) ? l : u;
      q_n1.push_back(lab);
      q_n2.push_back((l < u) ? u : l);
    end
    q_uf.push_back((b && l != 0 && u != 0 && l != u) ? 1 : 0);
    q_lab.push_back(lab);
    q_ovf.push_back(int'(m_ovf));
    m_line[m_col] = lab;
    m_left = lab;
    if (m_col == 7) begin
      m_col = 0;
      if (m_row == 3) begin
        m_run = 0;
        q_used.push_back(m_ovf ? 7 : m_next - 1);
        q_fovf.push_back(int'(m_ovf));
      end else m_row++;
    end else m_col++;
  endtask

  int got_lab[64];
  int ref_lab[64];
  int got_n, n_unions, last_used, last_ovf;
  int mon_lab, mon_ovf, mon_uf;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (uf_start && !label_valid) check_eq("uf_start_without_label", 1, 0);
      if (label_valid) begin
        if (q_lab.size() == 0) check_eq("label_extra", 1, 0);
        else begin
          mon_lab = q_lab.pop_front();
          mon_ovf = q_ovf.pop_front();
          mon_uf  = q_uf.pop_front();
          check_eq("label_out", int'(label_out), mon_lab);
          check_eq("label_overflow", int'(label_overflow), mon_ovf);
          check_eq("uf_start", int'(uf_start), mon_uf);
          if (mon_uf != 0) begin
            check_eq("uf_node1", int'(uf_node1), q_n1.pop_front());
            check_eq("uf_node2", int'(uf_node2), q_n2.pop_front());
            check_eq("uf_op", int'(uf_op), 1);
            check_eq("ready_in_wait", int'(pix_ready), 0);
          end
        end
        if (got_n < 64) got_lab[got_n] = int'(label_out);
        got_n++;
      end
      if (uf_start) n_unions++;
      if (frame_done) begin
        if (q_used.size() == 0) check_eq("frame_done_extra", 1, 0);
        else begin
          check_eq("labels_used", int'(labels_used), q_used.pop_front());
          check_eq("overflow_at_done", int'(label_overflow), q_fovf.pop_front());
        end
        last_used = int'(labels_used);
        last_ovf  = int'(label_overflow);
      end
    end
  end

  task automatic send_pix(input logic b, input logic s);
    int guard = 0;
    pix_valid = 1'b1; pix_bin = b; pix_sof = s;
    while (!pix_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("pix_ready_timeout", 0, 1);
    model_push(b, s);
    @(negedge clk);
    pix_valid = 1'b0; pix_sof = 1'b0; pix_bin = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3, input bit gaps);
    logic [31:0] img;
    img = {r0, r1, r2, r3};
    for (int i = 0; i < 32; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_pix(img[31-i], i == 0);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((q_lab.size() != 0 || q_used.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_done", (q_lab.size() == 0 && q_used.size() == 0) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t2_exp[8] = '{0, 1, 1, 0, 0, 0, 2, 2};
    logic [31:0] img6;
    reset_n = 1'b0; pix_valid = 1'b0; pix_bin = 1'b0; pix_sof = 1'b0;
    m_run = 0; got_n = 0; n_unions = 0; last_used = -1; last_ovf = -1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_pix_ready", int'(pix_ready), 1);
    check_eq("rst_label_valid", int'(label_valid), 0);
    check_eq("rst_uf_start", int'(uf_start), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    check_eq("rst_labels_used", int'(labels_used), 0);
    check_eq("rst_overflow", int'(label_overflow), 0);

    // All-background frame
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
    drain();
    check_eq("t1_unions", n_unions, 0);
    check_eq("t1_label_count", got_n, 32);
    check_eq("t1_labels_used", last_used, 0);

    // Two runs in row 0
    got_n = 0;
    send_frame(8'b0110_0011, 8'h00, 8'h00, 8'h00, 0);
    drain();
    for (int i = 0; i < 8; i++) check_eq($sformatf("t2_lab%0d", i), got_lab[i], t2_exp[i]);
    check_eq("t2_labels_used", last_used, 2);

    // U-shape joining labels 1 and 2
    got_n = 0; n_unions = 0;
    send_frame(8'b1010_0000, 8'b1110_0000, 8'h00, 8'h00, 0);
    drain();
    check_eq("t3_unions", n_unions, 1);
    for (int i = 8; i < 11; i++) check_eq($sformatf("t3_row1_lab%0d", i - 8), got_lab[i], 1);
    check_eq("t3_labels_used", last_used, 2);

    // Checkerboard exhausts the 3-bit label space
    got_n = 0;
    send_frame(8'b1010_1010, 8'b0101_0101, 8'b1010_1010, 8'b0101_0101, 0);
    drain();
    check_eq("t4_labels_used", last_used, 7);
    check_eq("t4_overflow", last_ovf, 1);
    check_eq("t4_last_fg_label", got_lab[31], 7);
    got_n = 0;
    send_frame(8'b1000_0000, 8'h00, 8'h00, 8'h00, 0);
    drain();
    check_eq("t4b_first_label", got_lab[0], 1);
    check_eq("t4b_overflow", last_ovf, 0);
    check_eq("t4b_labels_used", last_used, 1);

    // Merge-heavy frame, gapless then with random valid gaps
    got_n = 0; n_unions = 0;
    send_frame(8'b1010_1010, 8'b1111_1111, 8'b0101_0101, 8'b1111_1111, 0);
    drain();
    check_eq("t5_unions", n_unions, 4);
    check_eq("t5_labels_used", last_used, 5);
    for (int i = 0; i < 32; i++) ref_lab[i] = got_lab[i];
    got_n = 0;
    send_frame(8'b1010_1010, 8'b1111_1111, 8'b0101_0101, 8'b1111_1111, 1);
    drain();
    check_eq("t5_gap_count", got_n, 32);
    for (int i = 0; i < 32; i++) check_eq($sformatf("t5_gap_lab%0d", i), got_lab[i], ref_lab[i]);

    // Reset while a union is outstanding
    img6 = {8'b1010_0000, 8'b1110_0000, 8'h00, 8'h00};
    for (int i = 0; i < 11; i++) send_pix(img6[31-i], i == 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_uf_start", int'(uf_start), 0);
    check_eq("t6_rst_pix_ready", int'(pix_ready), 1);
    check_eq("t6_rst_label_valid", int'(label_valid), 0);
    q_lab.delete(); q_ovf.delete(); q_uf.delete(); q_n1.delete(); q_n2.delete();
    q_used.delete(); q_fovf.delete();
    m_run = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t6_ready_after_rst", int'(pix_ready), 1);
    got_n = 0;
    send_frame(8'b0100_0000, 8'h00, 8'h00, 8'h00, 0);
    drain();
    check_eq("t6_first_fg_label", got_lab[1], 1);
    check_eq("t6_labels_used", last_used, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccl_label_scan.md
# ccl_label_scan

First pass of connected-component labelling for the binary detection mask. Consumes the thresholded pixel stream in raster order, assigns a provisional label to every foreground pixel using 4-connectivity (left, up), and issues union requests to `union_find` whenever two different provisional labels touch. It sits directly upstream of `union_find`, drives its `op/node1/node2/start` and waits on its `done`.

## Interface
- `IMG_W`, 1280: pixels per line.
- `IMG_H`, 720: lines per frame.
- `ADDR_WIDTH`, 8: label width; must match `union_find.ADDR_WIDTH`. Label 0 = background.
- `COL_W`, 11: column counter width, ≥ clog2(IMG_W).
- `ROW_W`, 10: row counter width, ≥ clog2(IMG_H).

- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pix_valid` in 1: pixel qualifier.
- `pix_bin` in 1: 1 = foreground.
- `pix_sof` in 1: first pixel of frame; only meaningful with `pix_valid`.
- `pix_ready` out 1: block accepts the pixel when `pix_valid & pix_ready`.
- `label_valid` out 1: provisional label valid.
- `label_out` out ADDR_WIDTH: provisional label, 0 for background.
- `uf_op` out 2: always `UF_OP_UNION` (2'b01) when `uf_start` is high.
- `uf_node1`, `uf_node2` out ADDR_WIDTH: labels to merge.
- `uf_start` out 1: one-cycle request pulse.
- `uf_done` in 1: completion from `union_find`.
- `frame_done` out 1: one-cycle pulse after the last pixel and last union have completed.
- `labels_used` out ADDR_WIDTH: highest label allocated this frame; valid with `frame_done`.
- `label_overflow` out 1: sticky per frame; label space exhausted.

## Operation
- Per accepted foreground pixel at (row r, col c): L = label of (r, c-1), 0 if c = 0; U = label of (r-1, c), 0 if r = 0.
  - L = U = 0: assign `next_label`, then increment it. If `next_label` = 2^ADDR_WIDTH-1 already, assign that value, do not increment, and set `label_overflow`.
  - Exactly one non-zero, or L = U: assign the non-zero value.
  - L ≠ U, both non-zero: assign min(L,U) and issue union(min, max).
- Background pixel: label 0, no union.
- Each output label is written into the line buffer at column c, for use as U on the next row.
- FSM: `IDLE` → `RUN` on the first accepted pixel with `pix_sof`. `RUN` → `UF_WAIT` when a union is issued; `pix_ready` is 0 while in `UF_WAIT`. `UF_WAIT` → `RUN` on `uf_done`. After pixel (IMG_H-1, IMG_W-1) the FSM goes to `FLUSH`, which waits for any outstanding `uf_done`, then pulses `frame_done` and returns to `IDLE`.
- `pix_sof`:
  - Resets col/row to 0, `next_label` to 1 and `label_overflow` to 0.
  - If it arrives mid-frame in `RUN`, the current frame is abandoned without `frame_done`.
  - Pixels accepted in `IDLE` without `pix_sof` are dropped: `label_valid` stays 0.
- Column wraps IMG_W-1 → 0 and increments the row. L is forced to 0 at column 0; the line buffer is not cleared between rows.

## Timing
- Reset values: `pix_ready` 1; every other output 0; FSM in `IDLE`; `next_label` 1.
- Latency: `label_out`/`label_valid` are registered, appearing 1 cycle after pixel acceptance.
- `uf_start` and `uf_node1/2` are asserted in the same cycle as the corresponding `label_valid`. `uf_node*` hold until `uf_done`.
- `pix_ready` drops in the cycle after the union-generating pixel is accepted.
  - The earliest next acceptance is the cycle after `uf_done` is sampled high.
  - At most one union is outstanding at a time.
- Throughput: 1 pixel/clk without merges.
- `uf_done` arriving while no union is outstanding is ignored.
- Line buffer: registered-read SDP RAM. The read of column c+1 is issued when pixel c is accepted, so U is ready with zero bubbles. The read address is held while stalled.
- Reset asserted mid-frame or mid-`UF_WAIT`: immediate return to reset values. `union_find` must be reset by the same `reset_n`.

## Structure
- `ccl_pkg`: `UF_OP_FIND` = 2'b10, `UF_OP_UNION` = 2'b01, label typedef of ADDR_WIDTH bits, `LABEL_BG` = 0. This package is shared with `union_find`.
- Sub-module `ccl_line_buffer`: IMG_W × ADDR_WIDTH SDP RAM with read enable, intended for inferred BRAM.

## Test plan
All scenarios use IMG_W = 8, IMG_H = 4 and a behavioural `union_find` model with 3-cycle `done`.
- Reset with all-zero frame plus `pix_sof` → 32 labels of 0, no `uf_start`, `frame_done` with `labels_used` = 0.
- Row 0 = 0110_0011 → labels 0,1,1,0,0,0,2,2; `labels_used` = 2.
- Row 0 = 1010_0000, row 1 = 1110_0000 → row 1 labels 1,1,1. One union(1,2) is issued at row 1 col 2; `pix_ready` is low until `uf_done`.
- Checkerboard with ADDR_WIDTH = 3 → labels 1..7, then saturation at 7 with `label_overflow` = 1. A following `pix_sof` clears overflow and restarts at 1.
- `pix_valid` toggling randomly across a merge-heavy frame → label sequence identical to the gapless run.
- `reset_n` asserted during `UF_WAIT` → `uf_start` 0, `pix_ready` 1. The next frame labels from 1.
